sram_prog_loader: RTL and testbench

Sequences the board SRAM to fetch a length-prefixed program image and streams it, one 16-bit word at a time, into the instruction scheduler over a valid/ready interface. It owns all SRAM control pins and runs read-only. It buffers words in a small FIFO, so scheduler back-pressure never violates SRAM read timing. It sits between the SRAM pins and the scheduler's program input, and is started once per reset or per reload.

---
 rtl/sram_prog_loader.sv | 171 +++++++++++++++++
 tb/tb_sram_prog_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_prog_loader.sv
// Fetches a length-prefixed program image from a read-only SRAM and streams it
// word by word through a small FIFO onto a valid/ready scheduler interface.
module sram_prog_loader #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int PROG_BASE  = 0,
  parameter int MAX_WORDS  = 1024,
  parameter int RD_WAIT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DATA_W-1:0]               sram_dq_in,
  output logic [ADDR_W-1:0]               sram_addr,
  output logic                            sram_ce_n,
  output logic                            sram_oe_n,
  output logic                            sram_we_n,
  output logic                            sram_lb_n,
  output logic                            sram_ub_n,
  output logic                            out_valid,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_last,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            len_err,
  output logic [$clog2(MAX_WORDS):0]      word_count
);

  localparam int CNT_W  = $clog2(MAX_WORDS) + 1;
  localparam int WAIT_W = (RD_WAIT < 2) ? 1 : $clog2(RD_WAIT + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(PROG_BASE);
  localparam logic [DATA_W:0]   MAX_N     = (DATA_W + 1)'(MAX_WORDS);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);
  localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, RD_LEN, RD_WORD, DRAIN, DONE} state_t;

  state_t              state, state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]   next_addr;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    remaining;
  logic [CNT_W-1:0]    len_clamped;
  logic                len_too_big;
  logic                rd_go;
  logic                rd_end;
  logic                start_ok;
  logic                push;
  logic                pop;

  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic                fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      fifo_count;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A word read only begins when the FIFO has room, and once begun it always
  // runs its full RD_WAIT+1 cycles so the SRAM timing is never cut short.
  always_comb begin
    state_next = state;
    rd_go      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RD_LEN;
      end
      RD_LEN: begin
        busy  = 1'b1;
        rd_go = 1'b1;
        if (wait_cnt == WAIT_LAST)
          state_next = (len_clamped == '0) ? DONE : RD_WORD;
      end
      RD_WORD: begin
        busy  = 1'b1;
        rd_go = (wait_cnt != '0) || (fifo_count < DEPTH_C);
        if (rd_go && (wait_cnt == WAIT_LAST) && (remaining == ONE_CNT))
          state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (fifo_count == '0) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = RD_LEN;
      end
      default: state_next = IDLE;
    endcase
  end

  assign start_ok    = start && ((state == IDLE) || (state == DONE));
  assign rd_end      = rd_go && (wait_cnt == WAIT_LAST);
  assign push        = rd_end && (state == RD_WORD);
  assign pop         = out_valid && out_ready;
  assign len_too_big = {1'b0, sram_dq_in} > MAX_N;
  assign len_clamped = len_too_big ? MAX_CNT : CNT_W'(sram_dq_in);

  // Between reads the address bus parks on whatever was last driven.
  assign sram_addr = rd_go ? ((state == RD_LEN) ? BASE_ADDR : next_addr) : addr_q;
  assign sram_ce_n = ~rd_go;
  assign sram_oe_n = ~rd_go;
  assign sram_lb_n = ~rd_go;
  assign sram_ub_n = ~rd_go;
  assign sram_we_n = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      next_addr  <= '0;
      addr_q     <= '0;
      remaining  <= '0;
      len_err    <= 1'b0;
      word_count <= '0;
    end else begin
      addr_q <= sram_addr;
      if (rd_go) wait_cnt <= rd_end ? '0 : wait_cnt + WAIT_W'(1);
      if (start_ok) begin
        len_err    <= 1'b0;
        word_count <= '0;
      end else if (pop && (word_count != MAX_CNT)) begin
        word_count <= word_count + ONE_CNT;
      end
      if ((state == RD_LEN) && rd_end) begin
        if (len_too_big) len_err <= 1'b1;
        remaining <= len_clamped;
        next_addr <= BASE_ADDR + ADDR_W'(1);
      end
      if (push) begin
        remaining <= remaining - ONE_CNT;
        next_addr <= next_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= sram_dq_in;
        fifo_last[wr_ptr] <= (remaining == ONE_CNT);
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head outputs read zero while empty so stale entries never leak out.
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];

endmodule

// File: tb/tb_sram_prog_loader.sv
// Directed bench for sram_prog_loader: SRAM image model, immediate assertions
// at each check point, and a single linear stimulus sequence.
module tb_sram_prog_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] sram_dq_in;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy, done, len_err;
  logic [10:0] word_count;

  logic [15:0] mem [0:4095];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          xfer_cyc[$];

  sram_prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sram_dq_in (sram_dq_in),
    .sram_addr  (sram_addr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_lb_n  (sram_lb_n),
    .sram_ub_n  (sram_ub_n),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .len_err    (len_err),
    .word_count (word_count)
  );

  assign sram_dq_in = mem[sram_addr[11:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start is held for exactly one cycle (cycle 0); returns in cycle 1.
  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " sram_addr"}, 32'(sram_addr), 32'd0);
    checkOutput({tag, " ctrl_n"}, 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1f);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " out_data"}, 32'(out_data), 32'd0);
    checkOutput({tag, " out_last"}, 32'(out_last), 32'd0);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " done"}, 32'(done), 32'd0);
    checkOutput({tag, " len_err"}, 32'(len_err), 32'd0);
    checkOutput({tag, " word_count"}, 32'(word_count), 32'd0);
  endtask

  // Follows transfers until done (or stop_after transfers), comparing each
  // word against the image words 1..n_exp held in the SRAM model.
  task automatic collectWords(input string tag, input int n_exp, input int stop_after, input int budget);
    int idx = 0;
    int guard = 0;
    bit fin = 1'b0;
    xfer_cyc.delete();
    while (!fin) begin
      if (out_valid && out_ready) begin
        if (idx < n_exp) begin
          checkOutput({tag, " data"}, 32'(out_data), 32'(mem[idx + 1]));
          checkOutput({tag, " last"}, 32'(out_last), 32'(idx == n_exp - 1));
        end else begin
          checkOutput({tag, " extra word"}, 32'(idx), 32'(n_exp));
        end
        xfer_cyc.push_back(cyc);
        idx++;
        if (idx == stop_after) fin = 1'b1;
      end
      if (!fin) begin
        if (done) begin
          fin = 1'b1;
        end else if (guard >= budget) begin
          checkOutput({tag, " timeout done"}, 32'(done), 32'd1);
          fin = 1'b1;
        end else begin
          tick();
          guard++;
        end
      end
    end
    if (stop_after == 0) checkOutput({tag, " word total"}, 32'(idx), 32'(n_exp));
  endtask

  initial begin
    bit seen_valid;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checkResetValues("reset");
    reset = 1'b0;
    tick();

    $display("[TB] basic three-word load");
    mem[0] = 16'd3; mem[1] = 16'hA001; mem[2] = 16'hA002; mem[3] = 16'hA003;
    applyStimulus();
    checkOutput("t1 busy", 32'(busy), 32'd1);
    checkOutput("t1 len read ctrl", 32'({sram_ce_n, sram_oe_n, sram_lb_n, sram_ub_n}), 32'h0);
    checkOutput("t1 len addr", 32'(sram_addr), 32'd0);
    while (cyc < 4) tick();
    checkOutput("t1 first word addr", 32'(sram_addr), 32'd1);
    while (cyc < 6) tick();
    checkOutput("t1 valid early", 32'(out_valid), 32'd0);
    tick();
    collectWords("t1", 3, 0, 40);
    if (xfer_cyc.size() == 3) begin
      checkOutput("t1 xfer0 cycle", 32'(xfer_cyc[0]), 32'd7);
      checkOutput("t1 xfer1 cycle", 32'(xfer_cyc[1]), 32'd10);
      checkOutput("t1 xfer2 cycle", 32'(xfer_cyc[2]), 32'd13);
    end
    checkOutput("t1 done", 32'(done), 32'd1);
    checkOutput("t1 busy end", 32'(busy), 32'd0);
    checkOutput("t1 word_count", 32'(word_count), 32'd3);
    checkOutput("t1 len_err", 32'(len_err), 32'd0);

    $display("[TB] back-pressure with twenty words");
    mem[0] = 16'd20;
    for (int i = 1; i <= 20; i++) mem[i] = 16'hB000 + 16'(i);
    out_ready = 1'b0;
    applyStimulus();
    checkOutput("t2 done cleared", 32'(done), 32'd0);
    checkOutput("t2 count cleared", 32'(word_count), 32'd0);
    while (cyc < 60) tick();
    checkOutput("t2 stalled ce_n", 32'(sram_ce_n), 32'd1);
    checkOutput("t2 stalled addr", 32'(sram_addr), 32'd8);
    checkOutput("t2 head data", 32'(out_data), 32'hB001);
    checkOutput("t2 head valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    collectWords("t2", 20, 0, 200);
    if (xfer_cyc.size() >= 8)
      checkOutput("t2 buffered burst", 32'(xfer_cyc[7] - xfer_cyc[0]), 32'd7);
    checkOutput("t2 word_count", 32'(word_count), 32'd20);

    $display("[TB] zero-length image");
    mem[0] = 16'd0;
    seen_valid = 1'b0;
    applyStimulus();
    while (cyc < 4) begin
      if (out_valid) seen_valid = 1'b1;
      if (cyc == 3) checkOutput("t3 done early", 32'(done), 32'd0);
      tick();
    end
    if (out_valid) seen_valid = 1'b1;
    checkOutput("t3 done", 32'(done), 32'd1);
    checkOutput("t3 busy", 32'(busy), 32'd0);
    checkOutput("t3 valid seen", 32'(seen_valid), 32'd0);
    checkOutput("t3 word_count", 32'(word_count), 32'd0);

    $display("[TB] oversize length clamps");
    mem[0] = 16'd2000;
    for (int i = 1; i <= 1100; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    applyStimulus();
    collectWords("t4", 1024, 0, 3300);
    checkOutput("t4 len_err", 32'(len_err), 32'd1);
    checkOutput("t4 word_count", 32'(word_count), 32'd1024);
    checkOutput("t4 done", 32'(done), 32'd1);

    $display("[TB] reset in the middle of a load");
    mem[0] = 16'd10;
    for (int i = 1; i <= 10; i++) mem[i] = 16'hC000 + 16'(i);
    applyStimulus();
    collectWords("t5 pre", 10, 5, 100);
    tick();
    reset = 1'b1;
    tick();
    checkResetValues("t5 reset");
    reset = 1'b0;
    tick();
    applyStimulus();
    collectWords("t5 reload", 10, 0, 100);
    if (xfer_cyc.size() > 0) checkOutput("t5 reload first cycle", 32'(xfer_cyc[0]), 32'd7);
    checkOutput("t5 word_count", 32'(word_count), 32'd10);

    $display("[TB] start while busy and start from DONE");
    mem[0] = 16'd4;
    for (int i = 1; i <= 4; i++) mem[i] = 16'hD000 + 16'(i);
    applyStimulus();
    while (cyc < 5) tick();
    start = 1'b1;
    checkOutput("t6 busy at restart", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    collectWords("t6", 4, 0, 60);
    if (xfer_cyc.size() > 0) checkOutput("t6 first cycle", 32'(xfer_cyc[0]), 32'd7);
    checkOutput("t6 word_count", 32'(word_count), 32'd4);
    checkOutput("t6 done", 32'(done), 32'd1);
    applyStimulus();
    checkOutput("t6 reload done", 32'(done), 32'd0);
    checkOutput("t6 reload count", 32'(word_count), 32'd0);
    checkOutput("t6 reload busy", 32'(busy), 32'd1);
    collectWords("t6 reload", 4, 0, 60);
    checkOutput("t6 reload word_count", 32'(word_count), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
